mdu_issue: RTL

MDU_ISSUE -- requirements
Module: mdu_issue

---
 rtl/mdu_issue.sv | 125 ++++++++++++
 1 files changed

// File: rtl/mdu_issue.sv
// Issue sequencer between the execute stage and a multi-cycle multiply/divide unit.
// Holds the pipeline while one M-op runs, then writes its result to the register file.
module mdu_issue #(
    parameter int TIMEOUT = 100
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_rs1,
    input  logic [31:0] req_rs2,
    input  logic [4:0]  req_rd,
    input  logic        flush,
    output logic        req_ready,
    output logic        stall,
    output logic        mdu_start,
    output logic [2:0]  mdu_funct3,
    output logic [31:0] mdu_a,
    output logic [31:0] mdu_b,
    input  logic        mdu_busy,
    input  logic [31:0] mdu_result,
    output logic        wb_valid,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        err
);
    typedef enum logic [2:0] {IDLE, START, ACK, RUN, DRAIN, WB} state_t;

    localparam logic [7:0] TO = 8'(TIMEOUT);

    state_t     state;
    logic [4:0] rd_q;
    logic [7:0] cnt;
    logic       busy_seen;
    logic       wb_q;
    logic       timeout;

    assign timeout   = (cnt + 8'd1) == TO;
    assign req_ready = (state == IDLE);
    assign stall     = req_valid & ~flush & (state != WB);
    // A flush arriving in the writeback cycle itself must still kill the write.
    assign wb_valid  = wb_q & ~flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            rd_q       <= '0;
            cnt        <= '0;
            busy_seen  <= 1'b0;
            wb_q       <= 1'b0;
            mdu_start  <= 1'b0;
            mdu_funct3 <= '0;
            mdu_a      <= '0;
            mdu_b      <= '0;
            wb_rd      <= '0;
            wb_data    <= '0;
            err        <= 1'b0;
        end else begin
            mdu_start <= 1'b0;
            wb_q      <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid && !flush) begin
                        mdu_funct3 <= req_funct3;
                        mdu_a      <= req_rs1;
                        mdu_b      <= req_rs2;
                        rd_q       <= req_rd;
                        cnt        <= '0;
                        mdu_start  <= 1'b1;
                        state      <= START;
                    end
                end
                START: begin
                    // The start pulse is already out, so a flush must wait for the MDU.
                    if (flush) begin
                        busy_seen <= 1'b0;
                        state     <= DRAIN;
                    end else begin
                        state <= ACK;
                    end
                end
                ACK: begin
                    cnt <= cnt + 8'd1;
                    if (timeout) begin
                        err   <= 1'b1;
                        state <= IDLE;
                    end else if (flush) begin
                        busy_seen <= mdu_busy;
                        state     <= DRAIN;
                    end else if (mdu_busy) begin
                        state <= RUN;
                    end
                end
                RUN: begin
                    cnt <= cnt + 8'd1;
                    if (timeout) begin
                        err   <= 1'b1;
                        state <= IDLE;
                    end else if (flush) begin
                        busy_seen <= 1'b1;
                        state     <= DRAIN;
                    end else if (!mdu_busy) begin
                        wb_data <= mdu_result;
                        wb_rd   <= rd_q;
                        wb_q    <= (rd_q != 5'd0);
                        state   <= WB;
                    end
                end
                DRAIN: begin
                    cnt <= cnt + 8'd1;
                    if (timeout) begin
                        err   <= 1'b1;
                        state <= IDLE;
                    end else if (busy_seen && !mdu_busy) begin
                        state <= IDLE;
                    end else begin
                        busy_seen <= busy_seen | mdu_busy;
                    end
                end
                WB:      state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule
